// File: rtl/k005297_pgdes.sv
// rtl/k005297_pgdes.sv - page-number deserializer: 12-bit serial page field to parallel word with valid/overrun handshake
module k005297_pgdes (
    input  logic        i_MCLK,
    input  logic        i_SYS_RST_n,
    input  logic        i_CLK2M_PCEN_n,
    input  logic [19:0] i_ROT20_n,
    input  logic        i_PGDES_EN,
    input  logic        i_PGDES_SDIN,
    input  logic [11:0] i_PGDES_REF,
    input  logic        i_PGDES_RD,
    output logic [11:0] o_PGDES_Q,
    output logic        o_PGDES_VALID,
    output logic        o_PGDES_MATCH,
    output logic        o_PGDES_OVR,
    output logic        o_PGDES_BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] sr_q, sr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] q_q, q_d;
    logic        valid_q, valid_d;
    logic        match_q, match_d;
    logic        ovr_q, ovr_d;
    logic        busy_q, busy_d;

    logic        tick;
    logic        phase0;
    logic [11:0] sr_shift;
    logic        rot_unused;

    assign tick       = ~i_CLK2M_PCEN_n;
    assign phase0     = ~i_ROT20_n[0];
    assign sr_shift   = {i_PGDES_SDIN, sr_q[11:1]};
    // Only the phase-0 line frames the window; the rest of the rotator is unused here.
    assign rot_unused = ^i_ROT20_n[19:1];

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        valid_d = valid_q;
        match_d = match_q;
        ovr_d   = ovr_q;

        if (tick) begin
            // A host read is overridden by a completion on the same tick.
            if (i_PGDES_RD && valid_q && state_q != ST_DONE) begin
                valid_d = 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (i_PGDES_EN && phase0) begin
                        sr_d    = sr_shift;
                        cnt_d   = 4'd1;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!i_PGDES_EN) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else if (phase0) begin
                        sr_d  = sr_shift;
                        cnt_d = 4'd1;
                    end else begin
                        sr_d  = sr_shift;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd11) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    q_d     = sr_q;
                    match_d = (sr_q == i_PGDES_REF);
                    valid_d = 1'b1;
                    if (valid_q && !i_PGDES_RD) begin
                        ovr_d = 1'b1;
                    end
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end
                default: begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Busy covers the whole frame up to, but not including, the completion tick's result.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
        if (!i_SYS_RST_n) begin
            state_q <= ST_IDLE;
            sr_q    <= 12'h000;
            cnt_q   <= 4'd0;
            q_q     <= 12'h000;
            valid_q <= 1'b0;
            match_q <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            match_q <= match_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign o_PGDES_Q     = q_q;
    assign o_PGDES_VALID = valid_q;
    assign o_PGDES_MATCH = match_q;
    assign o_PGDES_OVR   = ovr_q;
    assign o_PGDES_BUSY  = busy_q;

endmodule

// File: tb/tb_k005297_pgdes.sv
// tb/tb_k005297_pgdes.sv - directed and randomized bench for k005297_pgdes against a frame-level reference model
module tb_k005297_pgdes;

    logic        clk;
    logic        rst_n;
    logic        pcen_n;
    logic [19:0] rot_n;
    logic        en;
    logic        sdin;
    logic [11:0] ref_w;
    logic        rd;
    logic [11:0] q;
    logic        valid;
    logic        match;
    logic        ovr;
    logic        busy;

    k005297_pgdes dut (
        .i_MCLK        (clk),
        .i_SYS_RST_n   (rst_n),
        .i_CLK2M_PCEN_n(pcen_n),
        .i_ROT20_n     (rot_n),
        .i_PGDES_EN    (en),
        .i_PGDES_SDIN  (sdin),
        .i_PGDES_REF   (ref_w),
        .i_PGDES_RD    (rd),
        .o_PGDES_Q     (q),
        .o_PGDES_VALID (valid),
        .o_PGDES_MATCH (match),
        .o_PGDES_OVR   (ovr),
        .o_PGDES_BUSY  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int phase   = 0;
    int busy_ticks = 0;

    // Reference model: frame position, accumulated word, pending completion.
    int          m_nbits;
    int          m_word;
    logic        m_pending;
    logic [11:0] m_q;
    logic        m_valid, m_match, m_ovr, m_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_q"},     {20'd0, q},     {20'd0, m_q});
        chk({tag, "_valid"}, {31'd0, valid}, {31'd0, m_valid});
        chk({tag, "_match"}, {31'd0, match}, {31'd0, m_match});
        chk({tag, "_ovr"},   {31'd0, ovr},   {31'd0, m_ovr});
        chk({tag, "_busy"},  {31'd0, busy},  {31'd0, m_busy});
    endtask

    task automatic model_reset();
        m_nbits = -1; m_word = 0; m_pending = 1'b0;
        m_q = 12'h000; m_valid = 1'b0; m_match = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_step(input logic t_en, input logic t_sd, input logic t_rd, input logic ph0);
        if (m_pending) begin
            if (m_valid && !t_rd) m_ovr = 1'b1;
            m_q       = m_word[11:0];
            m_match   = (m_word[11:0] == ref_w);
            m_valid   = 1'b1;
            m_pending = 1'b0;
            m_busy    = 1'b0;
        end else begin
            if (t_rd && m_valid) m_valid = 1'b0;
            if (m_nbits >= 0) begin
                if (!t_en) begin
                    m_nbits = -1;
                    m_busy  = 1'b0;
                end else if (ph0) begin
                    m_word  = int'(t_sd);
                    m_nbits = 1;
                end else begin
                    m_word  = m_word + (int'(t_sd) << m_nbits);
                    m_nbits = m_nbits + 1;
                    if (m_nbits == 12) begin
                        m_nbits   = -1;
                        m_pending = 1'b1;
                    end
                end
            end else if (t_en && ph0) begin
                m_word  = int'(t_sd);
                m_nbits = 1;
                m_busy  = 1'b1;
            end
        end
    endtask

    // One tick edge followed by one non-tick edge with noisy inputs.
    task automatic tick(input logic t_en, input logic t_sd, input logic t_rd, input logic inj);
        logic ph0;
        @(negedge clk);
        check_all("hold");
        en     = t_en;
        sdin   = t_sd;
        rd     = t_rd;
        pcen_n = 1'b0;
        rot_n  = inj ? ~20'd1 : ~(20'd1 << phase);
        ph0    = inj || (phase == 0);
        @(posedge clk);
        model_step(t_en, t_sd, t_rd, ph0);
        phase = (phase + 1) % 20;
        @(negedge clk);
        check_all("tick");
        if (busy) busy_ticks++;
        pcen_n = 1'b1;
        sdin   = 1'($urandom);
        rd     = 1'($urandom);
        en     = 1'($urandom);
        rot_n  = ~20'd1;
        @(posedge clk);
    endtask

    task automatic align();
        while (phase != 0) tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [11:0] w, input logic rd12);
        align();
        for (int p = 0; p < 20; p++)
            tick(1'b1, (p < 12) ? w[p] : 1'($urandom), (p == 12) ? rd12 : 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        pcen_n = 1'b1;
        rst_n  = 1'b0;
        model_reset();
        #1;
        check_all("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [11:0] w;
        int mode, cut;

        rst_n = 1'b1; pcen_n = 1'b1; rot_n = '1; en = 1'b0; sdin = 1'b0; ref_w = 12'h000; rd = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all("por");
        chk("por_q_const", {20'd0, q}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single frame with matching reference; busy must span 12 ticks.
        ref_w = 12'hA5C;
        align();
        busy_ticks = 0;
        send_frame(12'hA5C, 1'b0);
        chk("t1_q", {20'd0, q}, 32'hA5C);
        chk("t1_valid", {31'd0, valid}, 32'd1);
        chk("t1_match", {31'd0, match}, 32'd1);
        chk("t1_ovr", {31'd0, ovr}, 32'd0);
        chk("t1_busy_ticks", busy_ticks, 12);
        tick(1'b0, 1'b0, 1'b1, 1'b0);

        // Mismatch, then read.
        ref_w = 12'h124;
        send_frame(12'h123, 1'b0);
        chk("t2_q", {20'd0, q}, 32'h123);
        chk("t2_match", {31'd0, match}, 32'd0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_valid_rd", {31'd0, valid}, 32'd0);
        chk("t2_q_hold", {20'd0, q}, 32'h123);
        tick(1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun, sticky through read.
        send_frame(12'h001, 1'b0);
        send_frame(12'hFFF, 1'b0);
        chk("t3_q", {20'd0, q}, 32'hFFF);
        chk("t3_valid", {31'd0, valid}, 32'd1);
        chk("t3_ovr", {31'd0, ovr}, 32'd1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_ovr_sticky", {31'd0, ovr}, 32'd1);
        do_reset();
        chk("t3_ovr_rst", {31'd0, ovr}, 32'd0);

        // Read on the completion tick: completion wins, no overrun.
        send_frame(12'h0AA, 1'b0);
        send_frame(12'h355, 1'b1);
        chk("t4_q", {20'd0, q}, 32'h355);
        chk("t4_valid", {31'd0, valid}, 32'd1);
        chk("t4_ovr", {31'd0, ovr}, 32'd0);

        // Abort at phase 5.
        align();
        for (int p = 0; p < 20; p++) tick(p < 5, 1'($urandom), 1'b0, 1'b0);
        chk("t5_q_hold", {20'd0, q}, 32'h355);
        chk("t5_valid_hold", {31'd0, valid}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(12'h7E1, 1'b0);
        chk("t5_q_new", {20'd0, q}, 32'h7E1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);

        // Resync: phase-0 pulse injected at bit 6.
        w = 12'h9C3;
        align();
        for (int p = 0; p < 20; p++)
            tick(1'b1, (p >= 6 && p < 18) ? w[p-6] : 1'($urandom), 1'b0, p == 6);
        chk("t5_resync_q", {20'd0, q}, 32'h9C3);

        // Asynchronous reset mid-frame at phase 7.
        align();
        for (int p = 0; p < 7; p++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_busy_async", {31'd0, busy}, 32'd0);
        chk("t6_valid_async", {31'd0, valid}, 32'd0);
        chk("t6_q_async", {20'd0, q}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_w = 12'h555;
        send_frame(12'h555, 1'b0);
        chk("t6_q", {20'd0, q}, 32'h555);
        chk("t6_match", {31'd0, match}, 32'd1);

        // Randomized frames with reads, aborts and resyncs.
        for (int f = 0; f < 40; f++) begin
            w     = 12'($urandom);
            ref_w = ($urandom_range(0, 1) == 0) ? w : 12'($urandom);
            mode  = $urandom_range(0, 7);
            cut   = $urandom_range(1, 11);
            align();
            for (int p = 0; p < 20; p++) begin
                if (mode == 1)
                    tick(1'b1, (p >= 6 && p < 18) ? w[p-6] : 1'($urandom),
                         ($urandom_range(0, 3) == 0), p == 6);
                else
                    tick((mode == 0 && p >= cut) ? 1'b0 : 1'b1,
                         (p < 12) ? w[p] : 1'($urandom),
                         ($urandom_range(0, 3) == 0), 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        n_fail++;
        $display("FAIL timeout observed=running expected=finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
